// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the memory (slave).
// The request and address stay stable until ready returns the word for that request.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and drives a ready-latency instruction memory.
// It holds a fetched word while frozen, and drains an in-flight request before redirecting on a branch.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'hE1A0_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_freeze,
    input  logic                    i_branch_taken,
    input  logic [31:0]             i_branch_addr,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_instruction,
    output logic                    o_inst_valid
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] r_target;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;
    logic        w_req;
    logic        w_valid;
    logic [31:0] w_inst;
    logic        w_accept;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_branch_pc = i_branch_addr & ~32'd3;
    assign w_accept    = w_valid & ~i_freeze & ~i_branch_taken;

    // Request depends only on state and reset, so freeze never reaches the memory port.
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        w_inst  = NOP_INST;
        if (rst_n) begin
            case (r_state)
                S_REQ: begin
                    w_req = 1'b1;
                    if (imem.ready && !i_branch_taken) begin
                        w_valid = 1'b1;
                        w_inst  = imem.rdata;
                    end
                end
                S_HOLD: begin
                    w_valid = 1'b1;
                    w_inst  = r_inst_buf;
                end
                S_DRAIN: w_req = 1'b1;
                default: w_req = 1'b0;
            endcase
        end
    end

    assign imem.req      = w_req;
    assign imem.addr     = r_pc;
    assign o_pc          = w_pc_plus4;
    assign o_instruction = w_inst;
    assign o_inst_valid  = w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_inst_buf <= NOP_INST;
            r_target   <= 32'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem.ready) begin
                        if (i_branch_taken) begin
                            r_pc <= w_branch_pc;
                        end else if (i_freeze) begin
                            r_inst_buf <= imem.rdata;
                            r_state    <= S_HOLD;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end else if (i_branch_taken) begin
                        // The outstanding request cannot be withdrawn; remember where to go.
                        r_target <= w_branch_pc;
                        r_state  <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (i_branch_taken) begin
                        r_pc       <= w_branch_pc;
                        r_inst_buf <= NOP_INST;
                        r_state    <= S_REQ;
                    end else if (w_accept) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.ready) begin
                        r_pc    <= i_branch_taken ? w_branch_pc : r_target;
                        r_state <= S_REQ;
                    end else if (i_branch_taken) begin
                        r_target <= w_branch_pc;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
